// File: rtl/pwm_led_fader.sv
// pwm_led_fader: N-channel PWM LED intensity engine with per-channel fade.
// Levels span 0..2**PWM_BITS; each channel's current level moves toward its target on frame boundaries.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   wr_en         one-cycle level write strobe
//   wr_ch         channel index for the write (out-of-range indices ignored)
//   wr_level      requested level, clamped to 2**PWM_BITS
//   wr_fade       1: ramp toward level, 0: jump at next frame boundary
//   enable        per-channel output gate
//   pwm_out       registered PWM bits
//   fading        high while a channel's current level differs from its target
//   frame_start   one-cycle pulse while cnt==0 and prescaler==0
module pwm_led_fader #(
  parameter int CHANNELS        = 3,
  parameter int PWM_BITS        = 9,
  parameter int PRESCALE_BITS   = 7,
  parameter int FADE_STEP       = 1,
  parameter int FRAMES_PER_STEP = 4,
  parameter int CH_BITS         = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_BITS-1:0]  wr_ch,
  input  logic [PWM_BITS:0]   wr_level,
  input  logic                wr_fade,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] fading,
  output logic                frame_start
);

  localparam int LW = PWM_BITS + 1;
  localparam int FW =
    (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int STEP_I =
    (FADE_STEP > 2**PWM_BITS) ? 2**PWM_BITS : FADE_STEP;

  localparam logic [LW-1:0] LMAX  = LW'(2**PWM_BITS);
  localparam logic [LW-1:0] STEP  = LW'(STEP_I);
  localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_STEP - 1);

  logic [PRESCALE_BITS-1:0] pre;
  logic [PWM_BITS-1:0]      cnt;
  logic [FW-1:0]            fcnt;
  logic                     pre_wrap;
  logic                     boundary;
  logic                     step_bnd;
  logic                     wr_ok;
  logic [LW-1:0]            wr_clamp;

  assign pre_wrap = &pre;
  assign boundary = pre_wrap & (&cnt);
  assign step_bnd = boundary & (fcnt == FLAST);

  assign wr_ok = wr_en &&
    ({{(32-CH_BITS){1'b0}}, wr_ch} < 32'(CHANNELS));
  assign wr_clamp = (wr_level > LMAX) ? LMAX : wr_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      cnt         <= '0;
      fcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      pre         <= pre + 1'b1;
      frame_start <= boundary;
      if (pre_wrap) begin
        cnt <= cnt + 1'b1;
      end
      if (boundary) begin
        fcnt <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [LW-1:0] cur;
    logic [LW-1:0] tgt;
    logic [LW-1:0] diff;
    logic [LW-1:0] mv;
    logic [LW-1:0] nxt_cur;
    logic [LW-1:0] nxt_tgt;
    logic          mode;
    logic          sel;
    logic          up;
    logic          pwm_q;
    logic          fad_q;

    assign sel  = wr_ok && (wr_ch == CH_BITS'(g));
    assign up   = tgt > cur;
    assign diff = up ? (tgt - cur) : (cur - tgt);
    // Clamp the step to the remaining distance so a ramp never overshoots.
    assign mv   = (diff < STEP) ? diff : STEP;

    // Decisions use the pre-write tgt/mode; a write lands next boundary.
    always_comb begin
      nxt_cur = cur;
      if (boundary) begin
        if (!mode) begin
          nxt_cur = tgt;
        end else if (step_bnd) begin
          nxt_cur = up ? (cur + mv) : (cur - mv);
        end
      end
    end

    assign nxt_tgt = sel ? wr_clamp : tgt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cur   <= '0;
        tgt   <= '0;
        mode  <= 1'b0;
        pwm_q <= 1'b0;
        fad_q <= 1'b0;
      end else begin
        cur   <= nxt_cur;
        tgt   <= nxt_tgt;
        if (sel) begin
          mode <= wr_fade;
        end
        pwm_q <= enable[g] & ({1'b0, cnt} < cur);
        fad_q <= (nxt_cur != nxt_tgt);
      end
    end

    assign pwm_out[g] = pwm_q;
    assign fading[g]  = fad_q;
  end

endmodule

// File: tb/tb_pwm_led_fader.sv
// tb_pwm_led_fader: directed bench for pwm_led_fader.
// Two instances share stimulus: u_a (step 1) and u_b (step 3).
module tb_pwm_led_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [3:0] wr_level;
  logic       wr_fade;
  logic [2:0] enable;
  logic [2:0] pwm_a;
  logic [2:0] fad_a;
  logic       fs_a;
  logic [2:0] pwm_b;
  logic [2:0] fad_b;
  logic       fs_b;

  int n_cmp = 0;
  int n_bad = 0;
  int duty_a [3];
  int duty_b [3];
  logic [2:0] ffa;
  logic [2:0] ffb;

  always #5 clk = ~clk;

  pwm_led_fader #(
    .CHANNELS(3), .PWM_BITS(3), .PRESCALE_BITS(1),
    .FADE_STEP(1), .FRAMES_PER_STEP(2), .CH_BITS(2)
  ) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_level(wr_level), .wr_fade(wr_fade), .enable(enable),
    .pwm_out(pwm_a), .fading(fad_a), .frame_start(fs_a)
  );

  pwm_led_fader #(
    .CHANNELS(3), .PWM_BITS(3), .PRESCALE_BITS(1),
    .FADE_STEP(3), .FRAMES_PER_STEP(2), .CH_BITS(2)
  ) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_level(wr_level), .wr_fade(wr_fade), .enable(enable),
    .pwm_out(pwm_b), .fading(fad_b), .frame_start(fs_b)
  );

  task automatic wr(input logic [1:0] ch, input logic [3:0] lv,
                    input logic f);
    wr_en    = 1'b1;
    wr_ch    = ch;
    wr_level = lv;
    wr_fade  = f;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (fs_a !== 1'b1 && k < 40) begin
      @(negedge clk);
      wr_en = 1'b0;
      k++;
    end
    n_cmp++;
    if (fs_a !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_wait: frame_start=%b want 1 within 40", fs_a);
    end
  endtask

  // Counts pwm high cycles over the frame starting at the present
  // frame_start cycle; outputs lag cnt by one clk.
  task automatic measure();
    if (fs_a !== 1'b1) wait_frame();
    ffa = fad_a;
    ffb = fad_b;
    for (int c = 0; c < 3; c++) begin
      duty_a[c] = 0;
      duty_b[c] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
        duty_a[c] += int'(pwm_a[c]);
        duty_b[c] += int'(pwm_b[c]);
      end
    end
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pwm_a, fad_a, fs_a, pwm_b, fad_b, fs_b} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b%b%b %b%b%b want all 0",
               pwm_a, fad_a, fs_a, pwm_b, fad_b, fs_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    wr(2'd1, 4'd8, 1'b0);
    measure();
    n_cmp++;
    if (duty_a[1] !== 16) begin
      n_bad++;
      $display("FAIL pre_reset_duty: got %0d want 16", duty_a[1]);
    end
    repeat (5) @(negedge clk);
    do_reset();
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (fs_a === 1'b1) break;
    end
    n_cmp++;
    if (k !== 16) begin
      n_bad++;
      $display("FAIL first_frame_start: got %0d clks want 16", k);
    end
    measure();
    n_cmp++;
    if (duty_a[1] !== 0 || ffa !== 3'b000) begin
      n_bad++;
      $display("FAIL post_reset_level: duty %0d fad %b want 0 000",
               duty_a[1], ffa);
    end
  endtask

  task automatic test_immediate();
    measure();
    wr(2'd0, 4'd3, 1'b0);
    measure();
    n_cmp++;
    if (duty_a[0] !== 0) begin
      n_bad++;
      $display("FAIL imm_same_frame: got %0d want 0", duty_a[0]);
    end
    for (int f = 0; f < 2; f++) begin
      measure();
      n_cmp++;
      if (duty_a[0] !== 6) begin
        n_bad++;
        $display("FAIL imm_duty%0d: got %0d want 6", f, duty_a[0]);
      end
    end
  endtask

  task automatic test_limits();
    int lv [3] = '{8, 0, 15};
    int ex [3] = '{16, 0, 16};
    for (int j = 0; j < 3; j++) begin
      wr(2'd1, 4'(lv[j]), 1'b0);
      measure();
      measure();
      n_cmp++;
      if (duty_a[1] !== ex[j] || ffa[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL limit_lv%0d: duty %0d fad %b want %0d 0",
                 lv[j], duty_a[1], ffa[1], ex[j]);
      end
    end
  endtask

  task automatic test_fade_up();
    int ex [8] = '{0, 2, 2, 4, 4, 6, 6, 8};
    do_reset();
    wr(2'd2, 4'd4, 1'b1);
    for (int f = 0; f < 8; f++) begin
      measure();
      n_cmp++;
      if (duty_a[2] !== ex[f] || ffa[2] !== (f < 7)) begin
        n_bad++;
        $display("FAIL fade_up_f%0d: duty %0d fad %b want %0d %b",
                 f + 1, duty_a[2], ffa[2], ex[f], (f < 7));
      end
    end
  endtask

  task automatic test_fade_down();
    int ex [6] = '{10, 10, 4, 4, 2, 2};
    logic fx [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    wr(2'd0, 4'd8, 1'b0);
    wait_frame();
    wr(2'd0, 4'd1, 1'b1);
    measure();
    n_cmp++;
    if (duty_b[0] !== 16 || ffb[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL fade_dn_start: duty %0d fad %b want 16 0",
               duty_b[0], ffb[0]);
    end
    for (int f = 0; f < 6; f++) begin
      measure();
      n_cmp++;
      if (duty_b[0] !== ex[f] || ffb[0] !== fx[f]) begin
        n_bad++;
        $display("FAIL fade_dn_f%0d: duty %0d fad %b want %0d %b",
                 f + 2, duty_b[0], ffb[0], ex[f], fx[f]);
      end
    end
  endtask

  task automatic test_corners();
    do_reset();
    wr(2'd0, 4'd2, 1'b0);
    @(negedge clk);
    wr(2'd1, 4'd5, 1'b0);
    measure();
    measure();
    n_cmp++;
    if (duty_a[0] !== 4 || duty_a[1] !== 10 || duty_a[2] !== 0) begin
      n_bad++;
      $display("FAIL corner_setup: %0d %0d %0d want 4 10 0",
               duty_a[0], duty_a[1], duty_a[2]);
    end
    wr(2'd3, 4'd8, 1'b0);
    measure();
    measure();
    n_cmp++;
    if (duty_a[0] !== 4 || duty_a[1] !== 10 || duty_a[2] !== 0 ||
        ffa !== 3'b000) begin
      n_bad++;
      $display("FAIL bad_ch_write: %0d %0d %0d fad %b want 4 10 0 000",
               duty_a[0], duty_a[1], duty_a[2], ffa);
    end
    enable = 3'b110;
    measure();
    n_cmp++;
    if (duty_a[0] !== 0 || duty_a[1] !== 10) begin
      n_bad++;
      $display("FAIL enable_off: %0d %0d want 0 10",
               duty_a[0], duty_a[1]);
    end
    enable = 3'b111;
    measure();
    n_cmp++;
    if (duty_a[0] !== 4) begin
      n_bad++;
      $display("FAIL enable_on: got %0d want 4", duty_a[0]);
    end
    repeat (15) @(negedge clk);
    wr(2'd0, 4'd6, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (fs_a !== 1'b1) begin
      n_bad++;
      $display("FAIL bnd_align: frame_start %b want 1", fs_a);
    end
    measure();
    n_cmp++;
    if (duty_a[0] !== 4 || ffa[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bnd_write_hold: duty %0d fad %b want 4 1",
               duty_a[0], ffa[0]);
    end
    measure();
    n_cmp++;
    if (duty_a[0] !== 12 || ffa[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bnd_write_apply: duty %0d fad %b want 12 0",
               duty_a[0], ffa[0]);
    end
    wr(2'd2, 4'd8, 1'b1);
    measure();
    measure();
    measure();
    repeat (5) @(negedge clk);
    do_reset();
    for (int f = 0; f < 2; f++) begin
      measure();
      n_cmp++;
      if (duty_a[0] !== 0 || duty_a[1] !== 0 || duty_a[2] !== 0 ||
          ffa !== 3'b000) begin
        n_bad++;
        $display("FAIL rst_mid_fade%0d: %0d %0d %0d fad %b want 0s",
                 f, duty_a[0], duty_a[1], duty_a[2], ffa);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_ch    = 2'd0;
    wr_level = 4'd0;
    wr_fade  = 1'b0;
    enable   = 3'b111;
    @(negedge clk);
    do_reset();
    test_reset();
    test_immediate();
    test_limits();
    test_fade_up();
    test_fade_down();
    test_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
